// File: rtl/ppu_pkg.sv
// Shared video-bus definitions: PPU modes, region bounds, OAM DMA constants
// and the address-decode helpers used by the arbiter and the DMA engine.
package ppu_pkg;

    typedef enum logic [1:0] {
        H_BLANK = 2'd0,
        V_BLANK = 2'd1,
        SCAN    = 2'd2,
        DRAW    = 2'd3
    } PPU_STATES_t;

    // Which requester's read is in flight on the video bus.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CPU  = 2'd1,
        TAG_PPU  = 2'd2
    } rd_tag_t;

    localparam logic [15:0] VRAM_BASE    = 16'h8000;
    localparam logic [15:0] VRAM_END     = 16'h9FFF;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] OAM_END      = 16'hFE9F;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam int unsigned DMA_LEN      = 160;

    function automatic logic in_vram(input logic [15:0] addr);
        return (addr >= VRAM_BASE) && (addr <= VRAM_END);
    endfunction

    function automatic logic in_oam(input logic [15:0] addr);
        return (addr >= OAM_BASE) && (addr <= OAM_END);
    endfunction

    function automatic logic vram_page(input logic [7:0] hi);
        return (hi >= VRAM_BASE[15:8]) && (hi <= VRAM_END[15:8]);
    endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA sequencer: alternates READ/WRITE for DMA_LEN bytes from {src_hi, idx}
// to OAM_BASE+idx. A trigger restarts the copy from idx 0 in any state.
module oam_dma_engine #(
    parameter int unsigned DMA_LEN  = ppu_pkg::DMA_LEN,
    parameter logic [15:0] OAM_BASE = ppu_pkg::OAM_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig,
    input  logic [7:0]  trig_hi,
    input  logic [7:0]  vram_data,
    input  logic [7:0]  sys_data,
    output logic        active,
    output logic        vram_rd,
    output logic        sys_rd,
    output logic [15:0] src_addr,
    output logic        oam_wr,
    output logic [15:0] oam_addr,
    output logic [7:0]  oam_wdata
);
    import ppu_pkg::*;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] src_hi_q, src_hi_d;
    logic [7:0] idx_q, idx_d;
    logic       src_vram;

    assign src_vram = vram_page(src_hi_q);

    always_comb begin
        state_d  = state_q;
        src_hi_d = src_hi_q;
        idx_d    = idx_q;
        case (state_q)
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    state_d = ST_READ;
                    idx_d   = idx_q + 8'd1;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
        // A trigger wins over whatever the sequencer was about to do.
        if (trig) begin
            state_d  = ST_READ;
            src_hi_d = trig_hi;
            idx_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            src_hi_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            src_hi_q <= src_hi_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        active    = (state_q != ST_IDLE);
        vram_rd   = (state_q == ST_READ) && src_vram;
        sys_rd    = (state_q == ST_READ) && !src_vram;
        src_addr  = (state_q == ST_READ) ? {src_hi_q, idx_q} : '0;
        oam_wr    = (state_q == ST_WRITE);
        oam_addr  = oam_wr ? (OAM_BASE + {8'h00, idx_q}) : '0;
        oam_wdata = '0;
        if (oam_wr) begin
            oam_wdata = src_vram ? vram_data : sys_data;
        end
    end

endmodule

// File: rtl/vram_oam_arbiter.sv
// Single-port video bus arbiter (DMA > PPU > CPU) with OAM DMA via FF46.
// Build macro: OAM_DMA_EN enables the DMA engine; without it FF46 is ignored.
module vram_oam_arbiter #(
    parameter int unsigned DMA_LEN  = 160,
    parameter logic [15:0] OAM_BASE = 16'hFE00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_en,
    input  logic [1:0]  ppu_mode,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    input  logic        ppu_rd,
    input  logic [15:0] ppu_addr,
    output logic [7:0]  ppu_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] dma_src_addr,
    output logic        dma_src_rd,
    input  logic [7:0]  dma_src_data,
    output logic        dma_active
);
    import ppu_pkg::*;

    PPU_STATES_t mode;
    logic        ppu_owns_vram, ppu_owns_oam;
    logic        dma_trig, dma_act;
    logic        dma_vram_rd, dma_sys_rd, dma_oam_wr;
    logic [15:0] dma_src_a, dma_oam_a;
    logic [7:0]  dma_wdata;
    logic        dma_bus, ppu_grant, cpu_grant;
    rd_tag_t     tag_q, tag_d;

    // With the feature compiled out the engine never leaves IDLE, so every
    // DMA output is constant zero and arbitration reduces to PPU > CPU.
`ifdef OAM_DMA_EN
    assign dma_trig = cpu_wr && (cpu_addr == DMA_REG_ADDR);
`else
    assign dma_trig = 1'b0;
`endif

    oam_dma_engine #(
        .DMA_LEN  (DMA_LEN),
        .OAM_BASE (OAM_BASE)
    ) u_dma (
        .clk       (clk),
        .rst       (rst),
        .trig      (dma_trig),
        .trig_hi   (cpu_wdata),
        .vram_data (mem_rdata),
        .sys_data  (dma_src_data),
        .active    (dma_act),
        .vram_rd   (dma_vram_rd),
        .sys_rd    (dma_sys_rd),
        .src_addr  (dma_src_a),
        .oam_wr    (dma_oam_wr),
        .oam_addr  (dma_oam_a),
        .oam_wdata (dma_wdata)
    );

    assign mode          = PPU_STATES_t'(ppu_mode);
    assign ppu_owns_vram = lcd_en && (mode == DRAW);
    assign ppu_owns_oam  = lcd_en && ((mode == SCAN) || (mode == DRAW));
    assign dma_active    = dma_act;
    assign dma_src_rd    = dma_sys_rd && !rst;
    assign dma_src_addr  = dma_src_rd ? dma_src_a : '0;

    always_comb begin
        dma_bus   = !rst && (dma_vram_rd || dma_oam_wr);
        ppu_grant = !rst && ppu_rd && !dma_bus &&
                    ((in_vram(ppu_addr) && ppu_owns_vram) ||
                     (in_oam(ppu_addr) && ppu_owns_oam && !dma_act));
        cpu_grant = !rst && (cpu_rd || cpu_wr) && !dma_bus && !ppu_grant &&
                    ((in_vram(cpu_addr) && !ppu_owns_vram) ||
                     (in_oam(cpu_addr) && !ppu_owns_oam && !dma_act));

        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        tag_d     = TAG_NONE;
        if (dma_bus && dma_oam_wr) begin
            mem_addr  = dma_oam_a;
            mem_wr    = 1'b1;
            mem_wdata = dma_wdata;
        end else if (dma_bus) begin
            mem_addr = dma_src_a;
            mem_rd   = 1'b1;
        end else if (ppu_grant) begin
            mem_addr = ppu_addr;
            mem_rd   = 1'b1;
            tag_d    = TAG_PPU;
        end else if (cpu_grant) begin
            mem_addr = cpu_addr;
            if (cpu_wr) begin
                mem_wr    = 1'b1;
                mem_wdata = cpu_wdata;
            end else begin
                mem_rd = 1'b1;
                tag_d  = TAG_CPU;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= TAG_NONE;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign cpu_rdata = (tag_q == TAG_CPU) ? mem_rdata : 8'hFF;
    assign ppu_rdata = (tag_q == TAG_PPU) ? mem_rdata : 8'hFF;

endmodule

// File: tb/tb_vram_oam_arbiter.sv
// Scoreboard bench for vram_oam_arbiter: read expectations are queued when the
// strobe is driven and compared against rdata one cycle later.
module tb_vram_oam_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        lcd_en;
    logic [1:0]  ppu_mode;
    logic [15:0] cpu_addr;
    logic        cpu_rd, cpu_wr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        ppu_rd;
    logic [15:0] ppu_addr;
    logic [7:0]  ppu_rdata;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic [15:0] dma_src_addr;
    logic        dma_src_rd;
    logic [7:0]  dma_src_data = 8'h00;
    logic        dma_active;

    logic [7:0] ram     [0:65535];
    logic [7:0] exp_mem [0:65535];
    logic [7:0] sys     [0:65535];
    logic [7:0] cpu_q[$];
    logic [7:0] ppu_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    vram_oam_arbiter #(
        .DMA_LEN  (160),
        .OAM_BASE (16'hFE00)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lcd_en       (lcd_en),
        .ppu_mode     (ppu_mode),
        .cpu_addr     (cpu_addr),
        .cpu_rd       (cpu_rd),
        .cpu_wr       (cpu_wr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .ppu_rd       (ppu_rd),
        .ppu_addr     (ppu_addr),
        .ppu_rdata    (ppu_rdata),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .dma_src_addr (dma_src_addr),
        .dma_src_rd   (dma_src_rd),
        .dma_src_data (dma_src_data),
        .dma_active   (dma_active)
    );

    always #5 clk = ~clk;

    // Video RAM and system bus: both return read data on the following cycle.
    always @(posedge clk) begin
        if (mem_wr) ram[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= ram[mem_addr];
        if (dma_src_rd) dma_src_data <= sys[dma_src_addr];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        logic crd, prd;
        logic [7:0] e;
        crd = cpu_rd;
        prd = ppu_rd;
        @(posedge clk);
        #1;
        if (crd) begin
            check("cpu_q_depth", cpu_q.size(), 1);
            if (cpu_q.size() != 0) begin
                e = cpu_q.pop_front();
                check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, e});
            end
        end
        if (prd) begin
            check("ppu_q_depth", ppu_q.size(), 1);
            if (ppu_q.size() != 0) begin
                e = ppu_q.pop_front();
                check("ppu_rdata", {24'd0, ppu_rdata}, {24'd0, e});
            end
        end
    endtask

    task automatic clear_strobes();
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        ppu_rd = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_wr    = 1'b1;
        cpu_wdata = d;
        tick();
        cpu_wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp);
        cpu_addr = a;
        cpu_rd   = 1'b1;
        cpu_q.push_back(exp);
    endtask

    task automatic ppu_read(input logic [15:0] a, input logic [7:0] exp);
        ppu_addr = a;
        ppu_rd   = 1'b1;
        ppu_q.push_back(exp);
    endtask

    function automatic bit in_oam_tb(input logic [15:0] a);
        return (a >= 16'hFE00) && (a <= 16'hFE9F);
    endfunction

    task automatic dma_trigger(input logic [7:0] hi);
        cpu_write(16'hFF46, hi);
        cpu_addr = 16'h0000;
    endtask

    // Steps while DMA is active (up to stop_at cycles), counting OAM writes.
    task automatic run_dma(input bit cpu_probe, input bit ppu_probe, input int stop_at,
                           output int act, output int wr, output int fw, output int lw);
        act = 0; wr = 0; fw = -1; lw = -1;
        while (dma_active && act < stop_at) begin
            if (mem_wr && in_oam_tb(mem_addr)) begin
                if (fw < 0) fw = act;
                lw = act;
                wr++;
            end
            clear_strobes();
            if (cpu_probe && (act % 40 == 7)) cpu_read(16'hFE20, 8'hFF);
            if (ppu_probe) ppu_read(16'h9800, 8'hFF);
            act++;
            tick();
        end
        clear_strobes();
    endtask

    function automatic int oam_errors(input logic [15:0] src);
        int errs = 0;
        for (int i = 0; i < 160; i++) begin
            if (ram[16'hFE00 + 16'(i)] !== exp_mem[src + 16'(i)]) errs++;
        end
        return errs;
    endfunction

    initial begin
        int act, wr, fw, lw;
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 8'h00;
            exp_mem[i] = 8'h00;
            sys[i] = 8'h00;
        end
        for (int i = 0; i < 160; i++) begin
            sys[16'hC100 + 16'(i)] = 8'(i);
            sys[16'hD000 + 16'(i)] = 8'hA5 ^ 8'(i);
            exp_mem[16'hC100 + 16'(i)] = 8'(i);
            exp_mem[16'hD000 + 16'(i)] = 8'hA5 ^ 8'(i);
            ram[16'h8000 + 16'(i)] = 8'h3C + 8'(i);
            exp_mem[16'h8000 + 16'(i)] = 8'h3C + 8'(i);
        end

        rst = 1'b1; lcd_en = 1'b1; ppu_mode = 2'd0;
        cpu_addr = '0; cpu_wdata = '0; ppu_addr = '0;
        clear_strobes();
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_dma_active", dma_active, 0);
        check("rst_dma_src_rd", dma_src_rd, 0);
        check("rst_dma_src_addr", dma_src_addr, 0);
        check("rst_cpu_rdata", cpu_rdata, 8'hFF);
        check("rst_ppu_rdata", ppu_rdata, 8'hFF);
        rst = 1'b0;

        // H_BLANK CPU access
        cpu_addr = 16'h8010; cpu_wr = 1'b1; cpu_wdata = 8'h5A;
        #1;
        check("hb_wr_strobe", mem_wr, 1);
        check("hb_wr_addr", mem_addr, 16'h8010);
        check("hb_wr_data", mem_wdata, 8'h5A);
        tick();
        cpu_wr = 1'b0;
        exp_mem[16'h8010] = 8'h5A;
        cpu_read(16'h8010, 8'h5A);
        #1;
        check("hb_rd_strobe", mem_rd, 1);
        tick();
        clear_strobes();
        cpu_write(16'h9800, 8'h77); exp_mem[16'h9800] = 8'h77;
        cpu_write(16'hFE00, 8'h11); exp_mem[16'hFE00] = 8'h11;

        // DRAW lockout: CPU write dropped, PPU reads old byte
        ppu_mode = 2'd3;
        cpu_addr = 16'h9800; cpu_wr = 1'b1; cpu_wdata = 8'h33;
        ppu_read(16'h9800, 8'h77);
        #1;
        check("draw_cpu_wr_dropped", mem_wr, 0);
        check("draw_ppu_addr", mem_addr, 16'h9800);
        tick();
        clear_strobes();
        cpu_read(16'h9800, 8'hFF); tick(); clear_strobes();
        cpu_read(16'hFE00, 8'hFF); tick(); clear_strobes();

        // SCAN: PPU owns OAM and wins the single bus over a CPU VRAM read
        ppu_mode = 2'd2;
        ppu_read(16'hFE00, 8'h11);
        cpu_read(16'h8010, 8'hFF);
        tick();
        clear_strobes();
        ppu_mode = 2'd0;
        #1;
        check("scan_last_ppu_rdata", ppu_rdata, 8'h11);
        ppu_mode = 2'd2;
        ppu_read(16'h8010, 8'hFF);
        cpu_read(16'h8010, 8'h5A);
        tick();
        clear_strobes();

        // Write dropped in DRAW left the old byte
        ppu_mode = 2'd0;
        cpu_read(16'h9800, 8'h77); tick(); clear_strobes();

        // LCD off: CPU owns everything even in DRAW
        lcd_en = 1'b0; ppu_mode = 2'd3;
        cpu_read(16'hFE00, 8'h11);
        ppu_read(16'h9800, 8'hFF);
        tick();
        clear_strobes();
        lcd_en = 1'b1; ppu_mode = 2'd0;

        // Region edges
        cpu_read(16'h9FFF, 8'h00); #1; check("edge_9fff", mem_rd, 1); tick(); clear_strobes();
        cpu_read(16'hA000, 8'hFF); #1; check("edge_a000", mem_rd, 0); tick(); clear_strobes();
        cpu_read(16'hFE9F, 8'h00); #1; check("edge_fe9f", mem_rd, 1); tick(); clear_strobes();
        cpu_read(16'hFEA0, 8'hFF); #1; check("edge_fea0", mem_rd, 0); tick(); clear_strobes();
        cpu_addr = 16'h7FFF; cpu_wr = 1'b1; #1; check("edge_7fff_wr", mem_wr, 0); tick(); clear_strobes();

`ifdef OAM_DMA_EN
        // DMA copy from system RAM C100
        dma_trigger(8'hC1);
        check("dma_rise", dma_active, 1);
        run_dma(1'b1, 1'b0, 1000, act, wr, fw, lw);
        check("dma_c1_cycles", act, 320);
        check("dma_c1_writes", wr, 160);
        check("dma_c1_first_wr", fw, 1);
        check("dma_c1_last_wr", lw, 319);
        check("dma_c1_fall", dma_active, 0);
        check("dma_c1_oam", oam_errors(16'hC100), 0);

        // VRAM source while in DRAW: PPU starved for the whole transfer
        ppu_mode = 2'd3;
        dma_trigger(8'h80);
        run_dma(1'b0, 1'b1, 1000, act, wr, fw, lw);
        check("dma_80_cycles", act, 320);
        check("dma_80_writes", wr, 160);
        check("dma_80_oam", oam_errors(16'h8000), 0);
        ppu_mode = 2'd0;

        // Re-trigger at DMA cycle 100
        dma_trigger(8'hC1);
        run_dma(1'b0, 1'b0, 99, act, wr, fw, lw);
        check("dma_pre_retrig_cycles", act, 99);
        dma_trigger(8'hD0);
        check("dma_retrig_active", dma_active, 1);
        run_dma(1'b0, 1'b0, 1000, act, wr, fw, lw);
        check("dma_retrig_cycles", act, 320);
        check("dma_retrig_oam", oam_errors(16'hD000), 0);

        // Reset mid-transfer abandons it
        dma_trigger(8'hC1);
        run_dma(1'b0, 1'b0, 50, act, wr, fw, lw);
        rst = 1'b1;
        #1;
        check("dma_rst_no_wr", mem_wr, 0);
        tick();
        rst = 1'b0;
        check("dma_rst_inactive", dma_active, 0);
        wr = 0;
        for (int c = 0; c < 20; c++) begin
            if (mem_wr || dma_src_rd) wr++;
            tick();
        end
        check("dma_rst_quiet", wr, 0);
`else
        // FF46 writes have no effect in this build
        dma_trigger(8'hC1);
        check("nodma_active", dma_active, 0);
        wr = 0;
        for (int c = 0; c < 10; c++) begin
            if (mem_wr || dma_src_rd || dma_active) wr++;
            tick();
        end
        check("nodma_quiet", wr, 0);
        cpu_read(16'hFE00, 8'h11); tick(); clear_strobes();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vram_oam_arbiter.md
# vram_oam_arbiter

Arbiter and OAM DMA sequencer for the shared single-port video memory bus (VRAM 8000–9FFF, OAM FE00–FE9F). Grants each cycle to one of three requesters (OAM DMA engine, PPU fetcher, CPU) according to PPU mode and DMA state. Sits between the CPU memory map, the PPU's `PPU_ADDR`/`PPU_RD` port and the video RAM. Also snoops CPU writes to FF46 to run the 160-byte OAM DMA.

## Interface
Parameters:
- DMA_LEN, 160, bytes copied per DMA transfer.
- OAM_BASE, 16'hFE00, DMA destination base.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- lcd_en  in  1  LCDC[7]; 0 means the PPU owns nothing.
- ppu_mode  in  2  0=H_BLANK, 1=V_BLANK, 2=SCAN, 3=DRAW.
- cpu_addr  in  16  CPU address.
- cpu_rd  in  1  CPU read strobe.
- cpu_wr  in  1  CPU write strobe.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  CPU read data; valid the cycle after `cpu_rd`.
- ppu_rd  in  1  PPU read strobe.
- ppu_addr  in  16  PPU address.
- ppu_rdata  out  8  PPU read data; valid the cycle after `ppu_rd`.
- mem_addr  out  16  video RAM address.
- mem_rd  out  1  video RAM read; data returns the next cycle.
- mem_wr  out  1  video RAM write.
- mem_wdata  out  8  video RAM write data.
- mem_rdata  in  8  video RAM read data.
- dma_src_addr  out  16  system-bus source address for non-VRAM DMA sources.
- dma_src_rd  out  1  system-bus source read; data returns the next cycle.
- dma_src_data  in  8  system-bus source data.
- dma_active  out  1  DMA in progress.

## Operation
- **Region decode:** VRAM = 8000–9FFF, OAM = FE00–FE9F. Any other address is not this block's concern: no grant and no mem strobe.
- **Ownership when lcd_en=1:**
  - SCAN: PPU owns OAM.
  - DRAW: PPU owns VRAM and OAM.
  - H_BLANK / V_BLANK: CPU owns both.
- **Ownership when lcd_en=0:** CPU owns both.
- **Grant priority per cycle:** DMA > PPU > CPU. The DMA engine owns OAM for the whole time `dma_active` is high. It takes the bus in READ state only when the source is in VRAM.
- **Blocked CPU access:** read returns FF; write is dropped. There is no stall.
- **Blocked PPU read:** returns FF.
- **Read return path:** a one-cycle registered tag records which requester's read was granted. The granted requester gets `mem_rdata`; the other requester's rdata is FF.
- **DMA trigger:** `cpu_wr` with `cpu_addr`=FF46 latches src_hi=`cpu_wdata` and clears idx. The trigger is accepted in any PPU mode.
- **DMA FSM states:** IDLE → READ → WRITE → READ … → IDLE.
  - READ: source = {src_hi, idx}. If src_hi is 80–9F, drive `mem_rd` on the bus; otherwise drive `dma_src_rd`.
  - WRITE: `mem_wr` to OAM_BASE+idx with the returned byte; idx increments. If idx==DMA_LEN-1, go to IDLE; else go to READ.
- **Re-trigger:** an FF46 write while DMA is active restarts at idx 0 with the new src_hi. The restart takes effect on the next cycle and overrides the current state.
- **idx width:** 8 bits; never exceeds 159.
- **Reset:**
  - Outputs: `mem_rd`/`mem_wr`/`dma_src_rd`/`dma_active` = 0, addresses = 0, `mem_wdata` = 0, `cpu_rdata`/`ppu_rdata` = FF.
  - Internal: FSM = IDLE, read tag cleared. A reset mid-DMA abandons the transfer.

## Timing
- **Grant path:** combinational from the request to `mem_*` in the same cycle.
- **Read data:** rdata is valid exactly one cycle after the strobe.
- **DMA duration:**
  - `dma_active` rises the cycle after the FF46 write.
  - Total 2×DMA_LEN = 320 active cycles.
  - The first OAM write occurs 2 cycles after the trigger; the last occurs at cycle 320.
  - `dma_active` falls the cycle after the last WRITE.
- **Mode changes:** `ppu_mode` changes take effect on the same-cycle grant. A read granted in the last SCAN cycle still returns data to the PPU.
- **Simultaneous CPU and PPU requests to an owned region:** the owner wins; the loser sees FF or a dropped write.

## Configuration
- `OAM_DMA_EN` defined: DMA engine present as described.
- `OAM_DMA_EN` undefined:
  - FF46 writes are ignored; `dma_active`, `dma_src_rd` and the DMA write path are tied 0.
  - Arbitration is PPU > CPU only.

## Structure
- **Shared package `ppu_pkg`:** `PPU_STATES_t` (H_BLANK, V_BLANK, SCAN, DRAW), VRAM_BASE/VRAM_END, OAM_BASE/OAM_END, DMA_REG_ADDR=16'hFF46, DMA_LEN.
- **Sub-module `oam_dma_engine`:** FSM, src_hi, idx, and source/destination address generation. It exports a request, address, data and write strobe to the arbiter.

## Test plan
1. **H_BLANK CPU access:** in H_BLANK, CPU writes 5A to 8010 then reads 8010 → `mem_wr` that cycle; `cpu_rdata`=5A one cycle after the read.
2. **DRAW lockout:** in DRAW, CPU writes 33 to 9800 and the PPU reads 9800 in the same cycle → write dropped; `ppu_rdata` = old byte; a CPU read returns FF.
3. **DMA copy:** write C1 to FF46 with source RAM C100+i = i → exactly 320 `dma_active` cycles; OAM FE00+i = i for i=0..159; CPU reads of FE20 during DMA return FF.
4. **VRAM-source DMA in DRAW:** write 80 to FF46 while in DRAW → VRAM read cycles preempt PPU reads (PPU gets FF on those cycles); OAM ends equal to 8000–809F.
5. **Re-trigger and reset:** write D0 to FF46 at DMA cycle 100 → restart; 320 further cycles, final OAM = D000–D09F. Separately, assert rst mid-DMA → `dma_active`=0 next cycle, no further OAM writes.
6. **LCD off:** with lcd_en=0 and ppu_mode=DRAW, a CPU read of FE00 is granted and returns the RAM value.
